// File: rtl/mem_access_ctrl.sv
// Shares one byte-wide memory between instruction fetch and load/store; each access is split into big-endian byte beats.
// Latency: grant in IDLE, then N beats (IF 4, D 1/2/4), then a one-cycle done pulse; the next grant comes no earlier than N+2 cycles after the first.
// Backpressure: a requester holds req until its done pulse; the losing port simply waits, and the memory itself never stalls.
module mem_access_ctrl #(
   parameter int ADDR_W = 32,
   parameter bit RR_EN  = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [31:0]       if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [1:0]        d_size,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_done,
   output logic [31:0]       d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [1:0]        beat;        // current beat index
   logic [1:0]        last_beat;   // N-1 for the granted access
   logic              gnt_d;       // 1 = data port owns the current access
   logic              last_gnt_d;  // owner of the most recently completed access
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [31:0]       wdata_q;
   logic [23:0]       acc;         // previously received bytes of a load
   logic [31:0]       acc_nxt;
   logic              grant_vld;
   logic              grant_d_nxt;
   logic [1:0]        byte_sel;

   // A byte access is one beat, a half two, and both word encodings four.
   function automatic logic [1:0] size_last(input logic [1:0] sz);
      case (sz)
         2'b00:   size_last = 2'd0;
         2'b01:   size_last = 2'd1;
         default: size_last = 2'd3;
      endcase
   endfunction

   // Arbitration: a lone request wins; a tie goes to D when round-robin is off, else to whoever did not go last.
   always_comb begin
      grant_vld   = if_req | d_req;
      grant_d_nxt = d_req;
      if (if_req && d_req) begin
         grant_d_nxt = RR_EN ? ~last_gnt_d : 1'b1;
      end
   end

   // The incoming read byte shifts in at the bottom, so the lowest address ends up most significant.
   assign acc_nxt = {acc, mem_rdata};

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: requests are only looked at in IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_vld) state_nxt = XFER;
         XFER:    if (beat == last_beat) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: latch the granted request, step through beats, and deliver read data on the last beat.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat       <= 2'd0;
         last_beat  <= 2'd0;
         gnt_d      <= 1'b0;
         last_gnt_d <= 1'b0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= 32'h0;
         acc        <= 24'h0;
         if_rdata   <= 32'h0;
         d_rdata    <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  gnt_d <= grant_d_nxt;
                  beat  <= 2'd0;
                  acc   <= 24'h0;
                  if (grant_d_nxt) begin
                     addr_q    <= d_addr;
                     we_q      <= d_we;
                     wdata_q   <= d_wdata;
                     last_beat <= size_last(d_size);
                  end else begin
                     addr_q    <= if_addr;
                     we_q      <= 1'b0;
                     wdata_q   <= 32'h0;
                     last_beat <= 2'd3;
                  end
               end
            end
            XFER: begin
               acc  <= acc_nxt[23:0];
               beat <= beat + 2'd1;
               if (beat == last_beat) begin
                  if (!gnt_d) begin
                     if_rdata <= acc_nxt;
                  end else if (!we_q) begin
                     d_rdata <= acc_nxt;
                  end
               end
            end
            DONE: begin
               last_gnt_d <= gnt_d;
            end
            default: ;
         endcase
      end
   end

   // Store bytes leave MSB-first within the sized field.
   assign byte_sel  = last_beat - beat;

   // Memory and handshake outputs decode registered state only.
   assign mem_en    = (state == XFER);
   assign mem_we    = mem_en & we_q;
   assign mem_addr  = mem_en ? (addr_q + {{(ADDR_W-2){1'b0}}, beat}) : '0;
   assign mem_wdata = mem_en ? wdata_q[{byte_sel, 3'b000} +: 8] : 8'h0;
   assign if_done   = (state == DONE) & ~gnt_d;
   assign d_done    = (state == DONE) & gnt_d;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus queues expected beats and completions, a negedge monitor checks them.
// A second instance with RR_EN=0 runs the tie test to show fixed D priority.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, d_req, if_req0, d_req0;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic        d_we;
   logic [1:0]  d_size;

   logic        if_done, d_done, mem_en, mem_we, busy;
   logic [31:0] if_rdata, d_rdata, mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;

   logic        if_done0, d_done0, mem_en0, mem_we0, busy0;
   logic [31:0] if_rdata0, d_rdata0, mem_addr0;
   logic [7:0]  mem_wdata0, mem_rdata0;

   logic [7:0]  mem [0:255];

   int vectors = 0;
   int errors  = 0;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [7:0]  wdata;
   } beat_t;

   typedef struct {
      logic        is_d;
      logic [31:0] rdata;
   } done_t;

   beat_t beat_q[$];
   done_t done_q[$];
   done_t done0_q[$];

   always #5 clk = ~clk;

   mem_access_ctrl #(.ADDR_W(32), .RR_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_access_ctrl #(.ADDR_W(32), .RR_EN(1'b0)) dut0 (
      .clk(clk), .rst(rst),
      .if_req(if_req0), .if_addr(if_addr), .if_done(if_done0), .if_rdata(if_rdata0),
      .d_req(d_req0), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done0), .d_rdata(d_rdata0),
      .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
      .mem_rdata(mem_rdata0), .busy(busy0)
   );

   // Byte memory model: combinational read, write on the clock edge.
   assign mem_rdata  = mem[mem_addr[7:0]];
   assign mem_rdata0 = mem_addr0[7:0];

   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic push_beat(input logic [31:0] a, input logic we, input logic [7:0] wd);
      beat_t b;
      b.addr = a; b.we = we; b.wdata = wd;
      beat_q.push_back(b);
   endtask

   task automatic push_load(input logic [31:0] a, input int n);
      for (int i = 0; i < n; i++) push_beat(a + i, 1'b0, 8'h00);
   endtask

   task automatic push_done(input logic is_d, input logic [31:0] rd);
      done_t d;
      d.is_d = is_d; d.rdata = rd;
      done_q.push_back(d);
   endtask

   task automatic push_done0(input logic is_d, input logic [31:0] rd);
      done_t d;
      d.is_d = is_d; d.rdata = rd;
      done0_q.push_back(d);
   endtask

   // Monitor: every beat and every done pulse must match the head of its queue.
   always @(negedge clk) begin
      beat_t b;
      done_t d;
      if (mem_en) begin
         if (beat_q.size() == 0) begin
            chk("unexpected_beat", mem_addr, 32'hxxxxxxxx);
         end else begin
            b = beat_q.pop_front();
            chk("beat_addr", mem_addr, b.addr);
            chk("beat_we", {31'h0, mem_we}, {31'h0, b.we});
            if (b.we) chk("beat_wdata", {24'h0, mem_wdata}, {24'h0, b.wdata});
         end
      end
      if (if_done || d_done) begin
         if (done_q.size() == 0) begin
            chk("unexpected_done", {30'h0, if_done, d_done}, 32'h0);
         end else begin
            d = done_q.pop_front();
            chk("done_port", {30'h0, if_done, d_done}, {30'h0, ~d.is_d, d.is_d});
            chk("done_rdata", d.is_d ? d_rdata : if_rdata, d.rdata);
         end
      end
      if (mem_en0) chk("dut0_we", {31'h0, mem_we0}, 32'h0);
      if (if_done0 || d_done0) begin
         if (done0_q.size() == 0) begin
            chk("dut0_unexpected_done", {30'h0, if_done0, d_done0}, 32'h0);
         end else begin
            d = done0_q.pop_front();
            chk("dut0_done_port", {30'h0, if_done0, d_done0}, {30'h0, ~d.is_d, d.is_d});
            chk("dut0_done_rdata", d.is_d ? d_rdata0 : if_rdata0, d.rdata);
         end
      end
   end

   task automatic d_access(input string nm, input logic we, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd, input int exp_lat);
      int n;
      @(posedge clk); #1;
      d_we = we; d_size = sz; d_addr = a; d_wdata = wd; d_req = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!d_done && n < 50);
      d_req = 1'b0;
      chk(nm, n, exp_lat);
   endtask

   task automatic if_access(input string nm, input logic [31:0] a, input int exp_lat);
      int n;
      @(posedge clk); #1;
      if_addr = a; if_req = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!if_done && n < 50);
      if_req = 1'b0;
      chk(nm, n, exp_lat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
      mem[8'h10] = 8'h12; mem[8'h11] = 8'h34; mem[8'h12] = 8'h56; mem[8'h13] = 8'h78;
      mem[8'h30] = 8'hA1; mem[8'h31] = 8'hB2; mem[8'h32] = 8'hC3; mem[8'h33] = 8'hD4;
      mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
      rst = 1'b0;
      if_req = 1'b0; d_req = 1'b0; if_req0 = 1'b0; d_req0 = 1'b0;
      if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_we = 1'b0; d_size = 2'b00;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      chk("rst_ctrl", {27'h0, if_done, d_done, mem_en, mem_we, busy}, 32'h0);
      chk("rst_mem_bus", mem_addr | {24'h0, mem_wdata}, 32'h0);
      rst = 1'b1;

      // Tie with both held: RR alternates D, IF, D, IF; fixed priority gives D every time.
      push_load(32'h30, 4); push_done(1'b1, 32'hA1B2C3D4);
      push_load(32'h10, 4); push_done(1'b0, 32'h12345678);
      push_load(32'h30, 4); push_done(1'b1, 32'hA1B2C3D4);
      push_load(32'h10, 4); push_done(1'b0, 32'h12345678);
      for (int i = 0; i < 4; i++) push_done0(1'b1, 32'h30313233);
      @(posedge clk); #1;
      if_addr = 32'h10; d_addr = 32'h30; d_we = 1'b0; d_size = 2'b10; d_wdata = 32'h0;
      if_req = 1'b1; d_req = 1'b1; if_req0 = 1'b1; d_req0 = 1'b1;
      fork
         begin
            int cnt_a, n_a;
            cnt_a = 0; n_a = 0;
            while (cnt_a < 4 && n_a < 200) begin
               @(negedge clk); n_a++;
               if (if_done || d_done) cnt_a++;
            end
            if_req = 1'b0; d_req = 1'b0;
            chk("rr_done_count", cnt_a, 4);
         end
         begin
            int cnt_b, n_b;
            cnt_b = 0; n_b = 0;
            while (cnt_b < 4 && n_b < 200) begin
               @(negedge clk); n_b++;
               if (if_done0 || d_done0) cnt_b++;
            end
            if_req0 = 1'b0; d_req0 = 1'b0;
            chk("prio_done_count", cnt_b, 4);
         end
      join

      // IF-only fetch: four read beats, done five cycles after the grant.
      push_load(32'h10, 4); push_done(1'b0, 32'h12345678);
      if_access("if_latency", 32'h10, 6);

      // Word store goes out MSB first; d_rdata keeps the last load value.
      push_beat(32'h20, 1'b1, 8'hDE); push_beat(32'h21, 1'b1, 8'hAD);
      push_beat(32'h22, 1'b1, 8'hBE); push_beat(32'h23, 1'b1, 8'hEF);
      push_done(1'b1, 32'hA1B2C3D4);
      d_access("sw_latency", 1'b1, 2'b10, 32'h20, 32'hDEADBEEF, 6);

      // Half and byte loads from the stored word.
      push_load(32'h22, 2); push_done(1'b1, 32'h0000BEEF);
      d_access("lh_latency", 1'b0, 2'b01, 32'h22, 32'h0, 4);
      push_load(32'h21, 1); push_done(1'b1, 32'h000000AD);
      d_access("lb_latency", 1'b0, 2'b00, 32'h21, 32'h0, 3);

      // Word load across the top of the address space.
      push_beat(32'hFFFFFFFE, 1'b0, 8'h00); push_beat(32'hFFFFFFFF, 1'b0, 8'h00);
      push_beat(32'h00000000, 1'b0, 8'h00); push_beat(32'h00000001, 1'b0, 8'h00);
      push_done(1'b1, 32'h11223344);
      d_access("wrap_latency", 1'b0, 2'b10, 32'hFFFFFFFE, 32'h0, 6);

      // Size 11 behaves as a word.
      push_load(32'h10, 4); push_done(1'b1, 32'h12345678);
      d_access("size11_latency", 1'b0, 2'b11, 32'h10, 32'h0, 6);
      chk("if_rdata_held", if_rdata, 32'h12345678);

      // Reset during the second beat of a store: only the first byte lands.
      push_beat(32'h40, 1'b1, 8'hCA);
      @(posedge clk); #1;
      d_we = 1'b1; d_size = 2'b10; d_addr = 32'h40; d_wdata = 32'hCAFEF00D; d_req = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("abort_ctrl", {27'h0, if_done, d_done, mem_en, mem_we, busy}, 32'h0);
      chk("abort_rdata", if_rdata | d_rdata, 32'h0);
      d_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", {31'h0, busy}, 32'h0);
      chk("abort_mem40", {24'h0, mem[8'h40]}, 32'h000000CA);
      chk("abort_mem41_43", {8'h0, mem[8'h41], mem[8'h42], mem[8'h43]}, 32'h00EEEEEE);
      push_load(32'h40, 1); push_done(1'b1, 32'h000000CA);
      d_access("post_abort_lb", 1'b0, 2'b00, 32'h40, 32'h0, 3);

      // Drain and confirm every expectation was consumed.
      for (int i = 0; i < 20 && (beat_q.size() != 0 || done_q.size() != 0); i++) @(negedge clk);
      chk("beat_q_empty", beat_q.size(), 0);
      chk("done_q_empty", done_q.size(), 0);
      chk("done0_q_empty", done0_q.size(), 0);
      chk("dut0_idle", {23'h0, busy0, mem_wdata0}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences a single-ported, byte-wide unified memory and shares it between two requesters: the instruction-fetch port (IF) and the load/store data port (D).
- Serialises each 32-bit, 16-bit or 8-bit access into byte beats.
- Byte order is big-endian: the byte at the lowest address is the most significant byte.
- Sits between the core's fetch/memory stages and the byte-array memory, as the step from separate instruction/data memories to one shared memory.

Parameters:
- ADDR_W, 32, width of all address ports.
- RR_EN, 1, 1 = round-robin on simultaneous requests; 0 = D always has priority.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high until if_done.
- if_addr  in  ADDR_W  fetch byte address; stable while if_req is high.
- if_done  out  1  one-cycle pulse: fetch complete.
- if_rdata  out  32  fetched word; valid when if_done is high, held until the next IF completion.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  00 = byte, 01 = half, 10/11 = word.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  store data, right-justified.
- d_done  out  1  one-cycle pulse: data access complete.
- d_rdata  out  32  load data, right-justified, zero-extended; valid with d_done and held afterwards.
- mem_en  out  1  memory beat active.
- mem_we  out  1  byte write strobe.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte, combinational from mem_addr.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE, beat=0, last_grant=IF.
  - All outputs are 0, including if_rdata and d_rdata.
  - An in-flight access is aborted immediately; a partially written store stays partial.
- States:
  - IDLE: arbitrate.
  - XFER: perform beats.
  - DONE: pulse done for one cycle.
- IDLE:
  - Sample if_req/d_req.
  - Only one request: grant it.
  - Both requesting, RR_EN=1: grant the port that is not last_grant.
  - Both requesting, RR_EN=0: grant D.
  - On grant, latch addr, we, size and wdata; set N (IF: 4; D: 1/2/4 per d_size); beat=0; go to XFER.
  - No request: stay in IDLE.
- XFER, each cycle:
  - mem_en=1, mem_addr=addr+beat (wraps modulo 2^ADDR_W), mem_we=we for D stores (always 0 for IF).
  - mem_wdata = byte (N-1-beat) of wdata, so the MSB of the sized field goes out first.
  - Loads: accumulator <= {accumulator[23:0], mem_rdata} at the clock edge.
  - beat increments; after beat N-1, load the accumulator into the granted port's rdata register and go to DONE.
- DONE: the granted port's done=1 for exactly one cycle; last_grant=granted port; next state is IDLE. Requests are ignored in DONE.
- Latency: a request seen in IDLE at cycle t gives beats t+1..t+N, done at t+N+1, and the next grant no earlier than t+N+2.
- mem_* outputs are decoded from registered state only; there is no combinational path from req inputs.
- Store completion: d_rdata is not updated on a store; d_done still pulses.
- Misalignment: no check and no trap; bytes are accessed at consecutive addresses.
- Request dropped mid-access: protocol violation. The access completes and done still pulses.
- Back-to-back: a requester holding req continuously after done is re-granted subject to arbitration.
- Other port: the non-granted port's done stays low and its rdata holds its previous value.

Test Plan:
- IF-only fetch, memory bytes at 0x10..0x13 = 12 34 56 78 -> mem_addr 0x10..0x13 over 4 cycles, if_done at cycle t+5, if_rdata=0x12345678, mem_we never high.
- D store sw, addr 0x20, wdata 0xDEADBEEF -> writes DE, AD, BE, EF to 0x20..0x23 in order. Follow with lh at 0x22 -> d_rdata=0x0000BEEF after 2 beats; lb at 0x21 -> 0x000000AD after 1 beat.
- Simultaneous if_req/d_req held continuously, RR_EN=1 -> grants alternate D, IF, D, IF (first tie after reset goes to D). With RR_EN=0 -> D is granted every time.
- Address wrap: lw at 0xFFFFFFFE -> beats at FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Reset asserted in the 2nd beat of a sw -> mem_en/mem_we drop immediately, no done pulse; after release, state is IDLE, busy=0, and only the first byte is modified.
- d_size=11 -> behaves identically to word (4 beats).
